multicycle_fsm_control: RTL and testbench

//  Moore FSM that sequences the shared MIPS datapath over multiple cycles.

---
 rtl/multicycle_fsm_control.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_fsm_control.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_fsm_control.sv
// multicycle_fsm_control
// Moore control FSM for the multicycle MIPS datapath (shared ALU, register
// file, sign-extend and unified memory). Decodes the latched opcode, drives
// every datapath mux/enable per cycle, stalls on the memory ready handshake
// and counts retired instructions.
module multicycle_fsm_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;

    // State register: synchronous reset returns the sequencer to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: memory states hold on !mem_ready, opcode used only in DECODE/MEMADR
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // Output decode: Moore per state, mem_ready gates fetch/store completion; all zero in reset
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        retire      = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    case (opcode)
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                        default:                                       illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    retire   = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    retire   = mem_ready;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    retire   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    retire      = 1'b1;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    retire   = 1'b1;
                end
                S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_ADDIWB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                default: illegal_op = 1'b1;
            endcase
        end
    end

    // Retired-instruction counter, wraps modulo 2^CNT_W; retire is already masked by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (retire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign state       = r_state;
    assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_fsm_control.sv
// tb_multicycle_fsm_control
// Randomized bench: each instruction is expanded into a planned cycle list
// (state, mem_ready, opcode) from the instruction timing rules, driven into
// the DUT, and the sampled trace is compared against the expected outputs.
// A second instance with CNT_W=2 exercises counter wrap.
module tb_multicycle_fsm_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic        illegal_op, retire;
    logic [31:0] instr_count;

    logic        PCWrite_b, PCWriteCond_b, IorD_b, MemRead_b, MemWrite_b, IRWrite_b;
    logic        MemtoReg_b, RegDst_b, RegWrite_b, ALUSrcA_b;
    logic [1:0]  ALUSrcB_b, ALUOp_b, PCSource_b;
    logic [3:0]  state_b;
    logic        illegal_op_b, retire_b;
    logic [1:0]  instr_count_b;

    logic [15:0] w_ctrl;
    assign w_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    multicycle_fsm_control #(.CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .illegal_op(illegal_op), .retire(retire),
        .instr_count(instr_count)
    );

    multicycle_fsm_control #(.CNT_W(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite_b), .PCWriteCond(PCWriteCond_b), .IorD(IorD_b), .MemRead(MemRead_b),
        .MemWrite(MemWrite_b), .IRWrite(IRWrite_b), .MemtoReg(MemtoReg_b), .RegDst(RegDst_b),
        .RegWrite(RegWrite_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .ALUOp(ALUOp_b),
        .PCSource(PCSource_b), .state(state_b), .illegal_op(illegal_op_b), .retire(retire_b),
        .instr_count(instr_count_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic [5:0] op;
    } step_t;

    step_t       plan[$];
    logic [3:0]  o_st  [64];
    logic [15:0] o_ctrl[64];
    logic        o_ill [64];
    logic        o_ret [64];
    logic [31:0] o_cnt [64];
    logic [3:0]  post_state;
    logic [31:0] post_cnt;
    logic [1:0]  post_cnt_b;

    logic [31:0] m_cnt;
    logic [1:0]  m_cnt_b;
    int          checks   = 0;
    int          failures = 0;

    function automatic bit is_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    // Expected control vector for a given state and mem_ready, outside reset
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic rdy);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            4'd0:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1'b1; asb = 2'b10; end
            4'd3:  begin mr = 1'b1; iord = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mw = 1'b1; iord = 1'b1; end
            4'd6:  begin asa = 1'b1; aop = 2'b10; end
            4'd7:  begin rw = 1'b1; rd = 1'b1; end
            4'd8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            4'd9:  begin pcw = 1'b1; pcs = 2'b10; end
            4'd10: begin asa = 1'b1; asb = 2'b10; end
            4'd11: rw = 1'b1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
    endfunction

    function automatic bit exp_retire(input logic [3:0] st, input logic rdy);
        return (st == 4'd4) || (st == 4'd7) || (st == 4'd8) || (st == 4'd9) ||
               (st == 4'd11) || (st == 4'd5 && rdy);
    endfunction

    task automatic add_step(input logic [3:0] st, input logic rdy, input logic [5:0] op,
                            input bit scr);
        step_t s;
        s.st  = st;
        s.rdy = rdy;
        // opcode only matters in DECODE/MEMADR; elsewhere it may be garbage
        s.op  = (st == 4'd1 || st == 4'd2 || !scr) ? op : 6'($urandom);
        plan.push_back(s);
    endtask

    // Builds the cycle plan of one instruction and drives/samples it (no checking here)
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit scr);
        logic r;
        plan.delete();
        for (int k = 0; k < fw; k++) add_step(4'd0, 1'b0, op, scr);
        add_step(4'd0, 1'b1, op, scr);
        r = scr ? 1'($urandom_range(0, 1)) : 1'b1;
        add_step(4'd1, r, op, scr);
        case (op)
            OP_R: begin add_step(4'd6, r, op, scr); add_step(4'd7, r, op, scr); end
            OP_LW: begin
                add_step(4'd2, r, op, scr);
                for (int k = 0; k < mw; k++) add_step(4'd3, 1'b0, op, scr);
                add_step(4'd3, 1'b1, op, scr);
                add_step(4'd4, r, op, scr);
            end
            OP_SW: begin
                add_step(4'd2, r, op, scr);
                for (int k = 0; k < mw; k++) add_step(4'd5, 1'b0, op, scr);
                add_step(4'd5, 1'b1, op, scr);
            end
            OP_BEQ:  add_step(4'd8, r, op, scr);
            OP_J:    add_step(4'd9, r, op, scr);
            OP_ADDI: begin add_step(4'd10, r, op, scr); add_step(4'd11, r, op, scr); end
            default: ;
        endcase
        for (int i = 0; i < plan.size(); i++) begin
            mem_ready = plan[i].rdy;
            opcode    = plan[i].op;
            @(negedge clk);
            o_st[i]   = state;
            o_ctrl[i] = w_ctrl;
            o_ill[i]  = illegal_op;
            o_ret[i]  = retire;
            o_cnt[i]  = instr_count;
            @(posedge clk);
            #1;
        end
        post_state = state;
        post_cnt   = instr_count;
        post_cnt_b = instr_count_b;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset   = 1'b0;
        m_cnt   = '0;
        m_cnt_b = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            opcode    = 6'($urandom);
            @(negedge clk);
            checks++;
            if (w_ctrl !== 16'h0000) begin
                failures++;
                $display("FAIL reset_ctrl cyc=%0d got=%h exp=%h", i, w_ctrl, 16'h0000);
            end
            checks++;
            if ({illegal_op, retire} !== 2'b00) begin
                failures++;
                $display("FAIL reset_pulses cyc=%0d got=%b exp=00", i, {illegal_op, retire});
            end
        end
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_cnt   = '0;
        m_cnt_b = '0;
        checks++;
        if (state !== 4'd0 || instr_count !== 32'd0 || instr_count_b !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got st=%0d cnt=%0d cntb=%0d exp 0 0 0",
                     state, instr_count, instr_count_b);
        end
    endtask

    task automatic test_rtype;
        logic [3:0] exp_st[4];
        exp_st = '{4'd0, 4'd1, 4'd6, 4'd7};
        do_reset(1);
        run_instr(OP_R, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_st[i] !== exp_st[i]) begin
                failures++;
                $display("FAIL rtype_state step=%0d got=%0d exp=%0d", i, o_st[i], exp_st[i]);
            end
        end
        checks++;
        if (o_ctrl[3][8:7] !== 2'b11) begin
            failures++;
            $display("FAIL rtype_rwb RegDst,RegWrite got=%b exp=11", o_ctrl[3][8:7]);
        end
        checks++;
        if (post_state !== 4'd0 || post_cnt !== 32'd1) begin
            failures++;
            $display("FAIL rtype_post got st=%0d cnt=%0d exp st=0 cnt=1", post_state, post_cnt);
        end
        m_cnt   = 32'd1;
        m_cnt_b = 2'd1;
    endtask

    task automatic test_lw_wait;
        logic [3:0] exp_st[7];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
        run_instr(OP_LW, 0, 2, 1'b0);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (o_st[i] !== exp_st[i]) begin
                failures++;
                $display("FAIL lw_state step=%0d got=%0d exp=%0d", i, o_st[i], exp_st[i]);
            end
        end
        for (int i = 3; i < 6; i++) begin
            checks++;
            if ({o_ctrl[i][12], o_ctrl[i][13]} !== 2'b11) begin
                failures++;
                $display("FAIL lw_memrd step=%0d MemRead,IorD got=%b exp=11", i,
                         {o_ctrl[i][12], o_ctrl[i][13]});
            end
        end
        m_cnt   = m_cnt + 32'd1;
        m_cnt_b = m_cnt_b + 2'd1;
        checks++;
        if (post_cnt !== m_cnt) begin
            failures++;
            $display("FAIL lw_count got=%0d exp=%0d", post_cnt, m_cnt);
        end
    endtask

    task automatic test_beq;
        run_instr(OP_BEQ, 1, 0, 1'b1);
        checks++;
        if (o_st[2] !== 4'd1 || o_st[3] !== 4'd8) begin
            failures++;
            $display("FAIL beq_state got=%0d,%0d exp=1,8", o_st[2], o_st[3]);
        end
        checks++;
        if (o_ctrl[3][14] !== 1'b1 || o_ctrl[3][1:0] !== 2'b01 || o_ctrl[3][3:2] !== 2'b01) begin
            failures++;
            $display("FAIL beq_ctrl got=%h exp PCWriteCond=1 PCSource=01 ALUOp=01", o_ctrl[3]);
        end
        checks++;
        if (o_ctrl[2][15] !== 1'b0 || o_ctrl[3][15] !== 1'b0 || o_ret[3] !== 1'b1) begin
            failures++;
            $display("FAIL beq_pcwrite_retire got pcw=%b%b ret=%b exp pcw=00 ret=1",
                     o_ctrl[2][15], o_ctrl[3][15], o_ret[3]);
        end
        m_cnt   = m_cnt + 32'd1;
        m_cnt_b = m_cnt_b + 2'd1;
    endtask

    task automatic test_illegal;
        run_instr(6'b111111, 0, 0, 1'b1);
        checks++;
        if (o_ill[0] !== 1'b0 || o_ill[1] !== 1'b1) begin
            failures++;
            $display("FAIL illegal_pulse got=%b%b exp=01", o_ill[0], o_ill[1]);
        end
        checks++;
        if (o_ret[0] !== 1'b0 || o_ret[1] !== 1'b0 || post_state !== 4'd0 || post_cnt !== m_cnt) begin
            failures++;
            $display("FAIL illegal_after got ret=%b%b st=%0d cnt=%0d exp ret=00 st=0 cnt=%0d",
                     o_ret[0], o_ret[1], post_state, post_cnt, m_cnt);
        end
    endtask

    task automatic test_reset_midway;
        mem_ready = 1'b1;
        opcode    = OP_SW;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd5 || MemWrite !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre got st=%0d MemWrite=%b exp st=5 MemWrite=1", state, MemWrite);
        end
        @(posedge clk);
        #1;
        reset     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (w_ctrl !== 16'h0000 || retire !== 1'b0) begin
            failures++;
            $display("FAIL midrst_during got ctrl=%h ret=%b exp ctrl=0000 ret=0", w_ctrl, retire);
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
        m_cnt     = '0;
        m_cnt_b   = '0;
        checks++;
        if (state !== 4'd0 || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL midrst_after got st=%0d cnt=%0d exp st=0 cnt=0", state, instr_count);
        end
        @(negedge clk);
        checks++;
        if (w_ctrl !== exp_ctrl(4'd0, 1'b0) || retire !== 1'b0) begin
            failures++;
            $display("FAIL midrst_fetch got ctrl=%h ret=%b exp ctrl=%h ret=0",
                     w_ctrl, retire, exp_ctrl(4'd0, 1'b0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap;
        logic [1:0] exp_b;
        do_reset(1);
        for (int k = 1; k <= 5; k++) begin
            run_instr(OP_J, 0, 0, 1'b1);
            exp_b = 2'(k % 4);
            checks++;
            if (o_ret[0] !== 1'b0 || o_ret[1] !== 1'b0 || o_ret[2] !== 1'b1) begin
                failures++;
                $display("FAIL wrap_retire k=%0d got=%b%b%b exp=001", k, o_ret[0], o_ret[1], o_ret[2]);
            end
            checks++;
            if (post_cnt_b !== exp_b || post_cnt !== 32'(k)) begin
                failures++;
                $display("FAIL wrap_count k=%0d got b=%0d w=%0d exp b=%0d w=%0d",
                         k, post_cnt_b, post_cnt, exp_b, k);
            end
        end
        m_cnt   = 32'd5;
        m_cnt_b = 2'd1;
    endtask

    task automatic test_back_to_back_random;
        logic [5:0] ops[6];
        logic [5:0] op;
        int         sel;
        logic [3:0] st;
        logic       rdy;
        bit         ill;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        do_reset(1);
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 6);
            if (sel == 6) begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end else begin
                op = ops[sel];
            end
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
            for (int i = 0; i < plan.size(); i++) begin
                st  = plan[i].st;
                rdy = plan[i].rdy;
                ill = (st == 4'd1) && !is_legal(op);
                checks++;
                if (o_st[i] !== st) begin
                    failures++;
                    $display("FAIL rnd_state n=%0d step=%0d op=%b got=%0d exp=%0d", n, i, op, o_st[i], st);
                end
                checks++;
                if (o_ctrl[i] !== exp_ctrl(st, rdy)) begin
                    failures++;
                    $display("FAIL rnd_ctrl n=%0d step=%0d st=%0d got=%h exp=%h",
                             n, i, st, o_ctrl[i], exp_ctrl(st, rdy));
                end
                checks++;
                if (o_ill[i] !== ill || o_ret[i] !== exp_retire(st, rdy)) begin
                    failures++;
                    $display("FAIL rnd_pulse n=%0d step=%0d got ill=%b ret=%b exp ill=%b ret=%b",
                             n, i, o_ill[i], o_ret[i], ill, exp_retire(st, rdy));
                end
                checks++;
                if (o_cnt[i] !== m_cnt) begin
                    failures++;
                    $display("FAIL rnd_count n=%0d step=%0d got=%0d exp=%0d", n, i, o_cnt[i], m_cnt);
                end
                if (exp_retire(st, rdy)) begin
                    m_cnt   = m_cnt + 32'd1;
                    m_cnt_b = m_cnt_b + 2'd1;
                end
            end
            checks++;
            if (post_state !== 4'd0 || post_cnt !== m_cnt || post_cnt_b !== m_cnt_b) begin
                failures++;
                $display("FAIL rnd_post n=%0d got st=%0d cnt=%0d b=%0d exp st=0 cnt=%0d b=%0d",
                         n, post_state, post_cnt, post_cnt_b, m_cnt, m_cnt_b);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = '0;
        m_cnt     = '0;
        m_cnt_b   = '0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_reset_midway();
        test_wrap();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
